// File: rtl/ship_placement_ctrl_if.sv
// Signal bundle between the game's top-level controller and the ship-placement block.
// master drives the phase/limit/switch inputs; slave is the placement controller.
interface ship_placement_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int MAX_SHIPS   = 5
);
  localparam int CW = $clog2(MAX_SHIPS + 1);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  logic                      enable;
  logic [CW-1:0]             ship_limit;
  logic                      confirm;
  logic                      undo;

  logic [PW-1:0]             active_player;
  logic [CW-1:0]             placed_count;
  logic [CW-1:0]             remaining;
  logic [NUM_PLAYERS*CW-1:0] final_ships;
  logic [NUM_PLAYERS-1:0]    player_done;
  logic                      place_pulse;
  logic                      limit_clamped;
  logic                      all_done;

  modport master (
    output enable, ship_limit, confirm, undo,
    input  active_player, placed_count, remaining, final_ships,
           player_done, place_pulse, limit_clamped, all_done
  );

  modport slave (
    input  enable, ship_limit, confirm, undo,
    output active_player, placed_count, remaining, final_ships,
           player_done, place_pulse, limit_clamped, all_done
  );
endinterface

// File: rtl/ship_placement_ctrl.sv
// Ship-placement controller: counts confirmed placements per player against a
// latched limit, supports undo, hands the turn over and reports completion.
module ship_placement_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int MAX_SHIPS   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  ship_placement_ctrl_if.slave bus
);
  localparam int CW = $clog2(MAX_SHIPS + 1);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_SHIPS);
  localparam logic [PW-1:0] LAST_P = PW'(NUM_PLAYERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLACE, S_HANDOFF, S_DONE} state_t;

  state_t                           state_q, state_d;
  logic [CW-1:0]                    limit_q, limit_d;
  logic                             clamp_q, clamp_d;
  logic [PW-1:0]                    act_q, act_d;
  logic [NUM_PLAYERS-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [NUM_PLAYERS-1:0]           done_q, done_d;
  logic                             pulse_q, pulse_d;

  logic conf_s1_q, conf_s2_q, conf_hist_q;
  logic undo_s1_q, undo_s2_q, undo_hist_q;
  logic conf_edge, undo_edge;

  logic [CW-1:0] cur_cnt, cnt_inc, cnt_dec, lim_req;

  function automatic logic [CW-1:0] clamp_limit(input logic [CW-1:0] req);
    return (req > MAX_C) ? MAX_C : req;
  endfunction

  // Switch conditioning: two-flop synchroniser plus history flop for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conf_s1_q   <= 1'b0;
      conf_s2_q   <= 1'b0;
      conf_hist_q <= 1'b0;
      undo_s1_q   <= 1'b0;
      undo_s2_q   <= 1'b0;
      undo_hist_q <= 1'b0;
    end else begin
      conf_s1_q   <= bus.confirm;
      conf_s2_q   <= conf_s1_q;
      conf_hist_q <= conf_s2_q;
      undo_s1_q   <= bus.undo;
      undo_s2_q   <= undo_s1_q;
      undo_hist_q <= undo_s2_q;
    end
  end

  assign conf_edge = conf_s2_q & ~conf_hist_q;
  assign undo_edge = undo_s2_q & ~undo_hist_q;

  assign cur_cnt = cnt_q[act_q];
  assign cnt_inc = cur_cnt + 1'b1;
  assign cnt_dec = cur_cnt - 1'b1;
  assign lim_req = clamp_limit(bus.ship_limit);

  // Placement state and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      limit_q <= '0;
      clamp_q <= 1'b0;
      act_q   <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      clamp_q <= clamp_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    clamp_d = clamp_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pulse_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          limit_d = lim_req;
          clamp_d = (bus.ship_limit > MAX_C);
          if (lim_req == '0) begin
            state_d = S_DONE;
            done_d  = '1;
          end else begin
            state_d = S_PLACE;
          end
        end
      end
      S_PLACE: begin
        // Coincident confirm and undo edges cancel each other out
        if (conf_edge && !undo_edge && (cur_cnt < limit_q)) begin
          cnt_d[act_q] = cnt_inc;
          pulse_d      = 1'b1;
          if (cnt_inc == limit_q) begin
            done_d[act_q] = 1'b1;
            state_d       = (act_q == LAST_P) ? S_DONE : S_HANDOFF;
          end
        end else if (undo_edge && !conf_edge && (cur_cnt != '0)) begin
          cnt_d[act_q] = cnt_dec;
        end
      end
      S_HANDOFF: begin
        // A switch still held from the last placement must be released first
        if (!conf_s2_q) begin
          act_d   = act_q + 1'b1;
          state_d = S_PLACE;
        end
      end
      S_DONE: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!bus.enable && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      limit_d = '0;
      clamp_d = 1'b0;
      act_d   = '0;
      cnt_d   = '0;
      done_d  = '0;
      pulse_d = 1'b0;
    end
  end

  assign bus.active_player = act_q;
  assign bus.placed_count  = cur_cnt;
  assign bus.remaining     = limit_q - cur_cnt;
  assign bus.final_ships   = cnt_q;
  assign bus.player_done   = done_q;
  assign bus.place_pulse   = pulse_q;
  assign bus.limit_clamped = clamp_q;
  assign bus.all_done      = (state_q == S_DONE);

  a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst) cur_cnt <= limit_q);
  a_pulse_single: assert property (@(posedge clk) disable iff (!rst) pulse_q |=> !pulse_q);
  a_done_flags:   assert property (@(posedge clk) disable iff (!rst) (state_q == S_DONE) |-> (&done_q));
endmodule

// File: tb/tb_ship_placement_ctrl.sv
// Bench for ship_placement_ctrl: table of timed input steps with expected outputs
// fed through a scoreboard queue, plus latency and async-reset sequences.
module tb_ship_placement_ctrl;
  localparam int NP = 2;
  localparam int MS = 5;
  localparam int CW = $clog2(MS + 1);
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;

  typedef struct {
    string            name;
    logic [PW-1:0]    ap;
    logic [CW-1:0]    pc;
    logic [CW-1:0]    rem;
    logic [NP*CW-1:0] fs;
    logic [NP-1:0]    pd;
    logic             lc;
    logic             ad;
    logic             pl;
    int               pulses;
    bit               chk_ap;
    bit               chk_pulses;
  } exp_t;

  typedef struct {
    logic          en;
    logic [CW-1:0] lim;
    logic          cf;
    logic          ud;
    int            cyc;
    exp_t          e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ship_placement_ctrl_if #(.NUM_PLAYERS(NP), .MAX_SHIPS(MS)) bus ();
  ship_placement_ctrl #(.NUM_PLAYERS(NP), .MAX_SHIPS(MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   pulse_total = 0;
  logic prev_pulse = 1'b0;
  vec_t vecs[$];
  exp_t sb_q[$];

  // Pulse monitor: counts strobes and flags any strobe wider than one cycle
  always @(posedge clk) begin
    #1;
    if (bus.place_pulse) begin
      pulse_total++;
      checks++;
      if (prev_pulse) begin
        errors++;
        $display("FAIL pulse_width: place_pulse high on two consecutive cycles, required one");
      end
      prev_pulse = 1'b1;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string n, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d required %0d", n, what, act, exp);
    end
  endtask

  task automatic check_next();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      if (e.chk_ap) cmp(e.name, "active_player", 32'(bus.active_player), 32'(e.ap));
      cmp(e.name, "placed_count",  32'(bus.placed_count),  32'(e.pc));
      cmp(e.name, "remaining",     32'(bus.remaining),     32'(e.rem));
      cmp(e.name, "final_ships",   32'(bus.final_ships),   32'(e.fs));
      cmp(e.name, "player_done",   32'(bus.player_done),   32'(e.pd));
      cmp(e.name, "limit_clamped", 32'(bus.limit_clamped), 32'(e.lc));
      cmp(e.name, "all_done",      32'(bus.all_done),      32'(e.ad));
      cmp(e.name, "place_pulse",   32'(bus.place_pulse),   32'(e.pl));
      if (e.chk_pulses) cmp(e.name, "pulse_total", 32'(pulse_total), 32'(e.pulses));
    end
  endtask

  function automatic exp_t mk(input string n, input int ap, input int pc, input int rem,
                              input int fs, input int pd, input int lc, input int ad,
                              input int pl, input int pulses, input bit chk_ap, input bit chk_p);
    exp_t e;
    e.name = n; e.ap = PW'(ap); e.pc = CW'(pc); e.rem = CW'(rem);
    e.fs = (NP*CW)'(fs); e.pd = NP'(pd); e.lc = lc[0]; e.ad = ad[0]; e.pl = pl[0];
    e.pulses = pulses; e.chk_ap = chk_ap; e.chk_pulses = chk_p;
    return e;
  endfunction

  task automatic add(input string n, input int en, input int lim, input int cf, input int ud,
                     input int cyc, input int ap, input int pc, input int rem, input int fs,
                     input int pd, input int lc, input int ad, input int pl, input int pulses,
                     input bit chk_ap);
    vec_t v;
    v.en = en[0]; v.lim = CW'(lim); v.cf = cf[0]; v.ud = ud[0]; v.cyc = cyc;
    v.e = mk(n, ap, pc, rem, fs, pd, lc, ad, pl, pulses, chk_ap, 1'b1);
    vecs.push_back(v);
  endtask

  initial begin
    // name        en lim cf ud cyc  ap pc rem fs    pd lc ad pl pulses chk_ap
    add("idle",      0, 3, 0, 0, 2,   0, 0, 0, 'o00, 0, 0, 0, 0, 0,  1);
    add("start",     1, 3, 0, 0, 1,   0, 0, 3, 'o00, 0, 0, 0, 0, 0,  1);
    add("p0_c1",     1, 3, 1, 0, 3,   0, 1, 2, 'o01, 0, 0, 0, 1, 1,  1);
    add("p0_r1",     1, 3, 0, 0, 3,   0, 1, 2, 'o01, 0, 0, 0, 0, 1,  1);
    add("p0_c2",     1, 3, 1, 0, 3,   0, 2, 1, 'o02, 0, 0, 0, 1, 2,  1);
    add("p0_r2",     1, 3, 0, 0, 3,   0, 2, 1, 'o02, 0, 0, 0, 0, 2,  1);
    add("p0_c3",     1, 3, 1, 0, 3,   0, 3, 0, 'o03, 1, 0, 0, 1, 3,  1);
    add("handoff_h", 1, 3, 1, 0, 5,   0, 3, 0, 'o03, 1, 0, 0, 0, 3,  1);
    add("handoff_x", 1, 3, 0, 0, 3,   1, 0, 3, 'o03, 1, 0, 0, 0, 3,  1);
    add("p1_c1",     1, 3, 1, 0, 3,   1, 1, 2, 'o13, 1, 0, 0, 1, 4,  1);
    add("p1_r1",     1, 3, 0, 0, 3,   1, 1, 2, 'o13, 1, 0, 0, 0, 4,  1);
    add("p1_c2",     1, 3, 1, 0, 3,   1, 2, 1, 'o23, 1, 0, 0, 1, 5,  1);
    add("p1_r2",     1, 3, 0, 0, 3,   1, 2, 1, 'o23, 1, 0, 0, 0, 5,  1);
    add("p1_c3",     1, 3, 1, 0, 3,   1, 3, 0, 'o33, 3, 0, 1, 1, 6,  1);
    add("done_r",    1, 3, 0, 0, 3,   1, 3, 0, 'o33, 3, 0, 1, 0, 6,  1);
    add("done_cf",   1, 3, 1, 0, 3,   1, 3, 0, 'o33, 3, 0, 1, 0, 6,  1);
    add("done_ud",   1, 3, 0, 1, 3,   1, 3, 0, 'o33, 3, 0, 1, 0, 6,  1);
    add("done_exit", 0, 3, 0, 0, 1,   0, 0, 0, 'o00, 0, 0, 0, 0, 6,  1);
    add("clamp",     1, 7, 0, 0, 1,   0, 0, 5, 'o00, 0, 1, 0, 0, 6,  1);
    add("cl_c1",     1, 7, 1, 0, 3,   0, 1, 4, 'o01, 0, 1, 0, 1, 7,  1);
    add("cl_r1",     1, 7, 0, 0, 3,   0, 1, 4, 'o01, 0, 1, 0, 0, 7,  1);
    add("cl_c2",     1, 7, 1, 0, 3,   0, 2, 3, 'o02, 0, 1, 0, 1, 8,  1);
    add("cl_r2",     1, 7, 0, 0, 3,   0, 2, 3, 'o02, 0, 1, 0, 0, 8,  1);
    add("undo_2to1", 1, 7, 0, 1, 3,   0, 1, 4, 'o01, 0, 1, 0, 0, 8,  1);
    add("undo_r1",   1, 7, 0, 0, 3,   0, 1, 4, 'o01, 0, 1, 0, 0, 8,  1);
    add("undo_1to0", 1, 7, 0, 1, 3,   0, 0, 5, 'o00, 0, 1, 0, 0, 8,  1);
    add("undo_r2",   1, 7, 0, 0, 3,   0, 0, 5, 'o00, 0, 1, 0, 0, 8,  1);
    add("undo_at0",  1, 7, 0, 1, 3,   0, 0, 5, 'o00, 0, 1, 0, 0, 8,  1);
    add("undo_r3",   1, 7, 0, 0, 3,   0, 0, 5, 'o00, 0, 1, 0, 0, 8,  1);
    add("both",      1, 7, 1, 1, 3,   0, 0, 5, 'o00, 0, 1, 0, 0, 8,  1);
    add("both_r",    1, 7, 0, 0, 3,   0, 0, 5, 'o00, 0, 1, 0, 0, 8,  1);
    add("held_1",    1, 7, 1, 0, 3,   0, 1, 4, 'o01, 0, 1, 0, 1, 9,  1);
    add("held_50",   1, 7, 1, 0, 50,  0, 1, 4, 'o01, 0, 1, 0, 0, 9,  1);
    add("held_r",    1, 7, 0, 0, 3,   0, 1, 4, 'o01, 0, 1, 0, 0, 9,  1);
    add("held_c2",   1, 7, 1, 0, 3,   0, 2, 3, 'o02, 0, 1, 0, 1, 10, 1);
    add("abort",     0, 7, 0, 0, 1,   0, 0, 0, 'o00, 0, 0, 0, 0, 10, 1);
    add("lim0",      1, 0, 0, 0, 3,   0, 0, 0, 'o00, 3, 0, 1, 0, 10, 0);
    add("lim0_exit", 0, 0, 0, 0, 3,   0, 0, 0, 'o00, 0, 0, 0, 0, 10, 1);

    bus.enable = 1'b0; bus.ship_limit = '0; bus.confirm = 1'b0; bus.undo = 1'b0;

    // Reset state while rst is held low
    @(negedge clk);
    sb_q.push_back(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1));
    check_next();
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.enable     = vecs[i].en;
      bus.ship_limit = vecs[i].lim;
      bus.confirm    = vecs[i].cf;
      bus.undo       = vecs[i].ud;
      sb_q.push_back(vecs[i].e);
      repeat (vecs[i].cyc) @(posedge clk);
      @(negedge clk);
      check_next();
    end

    // Latency: confirm rises before edge k, count and pulse appear after edge k+2
    bus.enable = 1'b1; bus.ship_limit = CW'(3);
    @(posedge clk);
    @(negedge clk);
    bus.confirm = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back(mk($sformatf("lat_k%0d", k), 0, (k >= 2) ? 1 : 0, (k >= 2) ? 2 : 3,
                        (k >= 2) ? 'o01 : 'o00, 0, 0, 0, (k == 2) ? 1 : 0, 0, 1'b1, 1'b0));
      @(posedge clk);
      @(negedge clk);
      check_next();
    end

    // Asynchronous reset mid-cycle during placement clears everything at once
    bus.confirm = 1'b0;
    #2 rst = 1'b0;
    sb_q.push_back(mk("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0));
    #1 check_next();
    #3 rst = 1'b1;
    sb_q.push_back(mk("rst_restart", 0, 0, 3, 'o00, 0, 0, 0, 0, 0, 1'b1, 1'b0));
    @(posedge clk);
    @(negedge clk);
    check_next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ship_placement_ctrl.md
# ship_placement_ctrl

Parametrised ship-placement controller for the Battleship game. It counts confirmed placements per player against a latched ship limit and supports undo. It hands the turn from player to player and reports per-player totals and completion. It sits between the game's top-level state machine, which drives `enable` during the placing-ships phase, and the board/display logic, which consumes the counts and done flags.

## Interface
Parameters:
- `NUM_PLAYERS`, 2: number of players placing in turn (≥1).
- `MAX_SHIPS`, 5: largest ship limit accepted (≥1).
- `CW` (localparam): `$clog2(MAX_SHIPS+1)`, counter width.
- `PW` (localparam): `max(1, $clog2(NUM_PLAYERS))`, player index width.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `enable` in 1: placing-ships phase active (level).
- `ship_limit` in CW: requested ships per player. Sampled only on IDLE→PLACE.
- `confirm` in 1: raw switch, active-high, asynchronous to `clk`.
- `undo` in 1: raw switch, active-high, asynchronous to `clk`.
- `active_player` out PW: index of the player currently placing.
- `placed_count` out CW: ships placed by `active_player`.
- `remaining` out CW: latched limit minus `placed_count`.
- `final_ships` out NUM_PLAYERS*CW: per-player counts. Player i occupies bits [i*CW +: CW].
- `player_done` out NUM_PLAYERS: player i has reached the limit.
- `place_pulse` out 1: one-cycle strobe on each accepted placement.
- `limit_clamped` out 1: latched limit was reduced to MAX_SHIPS.
- `all_done` out 1: every player finished (DONE state).

## Operation
- **Input conditioning:**
  - `confirm` and `undo` each pass through a 2-flop synchroniser, then a history flop.
  - Edge = sync2 & ~hist. One edge per press, regardless of hold length.
- **States:** IDLE, PLACE, HANDOFF, DONE.
- **IDLE:**
  - All counts 0, `active_player`=0, outputs idle.
  - On `enable`=1:
    - Latch limit L = min(`ship_limit`, MAX_SHIPS).
    - Set `limit_clamped` if `ship_limit` > MAX_SHIPS.
    - If L=0, go to DONE with all `player_done` set. Otherwise go to PLACE.
- **PLACE:**
  - Confirm edge with count < L: count+1, `place_pulse`=1.
  - Undo edge with count > 0: count−1. No pulse.
  - Confirm and undo edges in the same cycle: neither acts.
  - Undo at count 0: ignored.
  - When count becomes L: set `player_done[active]`.
    - If `active_player` = NUM_PLAYERS−1, go to DONE.
    - Otherwise go to HANDOFF.
- **HANDOFF:**
  - Wait until synchronised `confirm`=0, so a held switch does not count for the next player.
  - Then `active_player`+1 and return to PLACE.
  - Edges arriving during HANDOFF are discarded.
- **DONE:**
  - `all_done`=1. Counts held.
  - Confirm and undo ignored.
  - `enable`=0 returns to IDLE, clearing counts, flags and `limit_clamped`.
- **Abort:** `enable`=0 in PLACE or HANDOFF returns to IDLE next edge and clears all counts.
- **Arithmetic:**
  - Counters never exceed L and never wrap below 0.
  - `remaining` = L − `placed_count`. Always in range, no wrap.
- **Outputs in DONE:** `placed_count` and `remaining` reflect the last player.

## Timing
- Reset (`rst`=0, async):
  - State IDLE.
  - Synchroniser and history flops 0.
  - All counts, `active_player`, `player_done`, `place_pulse`, `limit_clamped`, `all_done`, `remaining` = 0.
- Reset deasserted mid-placement: restart from IDLE. No state retained.
- Button latency: if `confirm` is high before edge k and stays high, `placed_count` updates and `place_pulse` is high after edge k+2. Same for `undo`.
- `place_pulse` is exactly one cycle wide.
- Final confirm to state change: PLACE→HANDOFF or PLACE→DONE occurs on the same edge as the increment. `player_done`/`all_done` are visible after that edge.
- HANDOFF exit: the edge after synchronised `confirm` is seen low.
- `enable` is synchronous, used directly, and has one-edge response.

## Test plan
- **Basic count:** NUM_PLAYERS=2, MAX_SHIPS=5, `ship_limit`=3, three clean confirm presses on player 0.
  - `place_pulse` ×3; counts 1,2,3.
  - `player_done`=01, HANDOFF, then `active_player`=1 after release.
  - Three more presses → `all_done`=1, `final_ships`={3,3}.
- **Held switch:** `confirm` held 50 cycles → exactly one increment. Holding through the limit does not count for player 1 until released and re-pressed.
- **Undo:**
  - Counts 2 → undo → 1.
  - Undo at 0 → stays 0.
  - Simultaneous confirm+undo edges → count unchanged, no pulse.
- **Limits:**
  - `ship_limit`=7 with MAX_SHIPS=5 → L=5, `limit_clamped`=1.
  - `ship_limit`=0 → DONE immediately, `player_done`=all ones.
- **Abort/reset:**
  - `enable` dropped at count 2 → IDLE, all counts 0.
  - `rst` pulsed low mid-PLACE (not on an edge) → all outputs 0 immediately.
- **Latency:** `confirm` rises just before edge k → `placed_count` changes after edge k+2, not earlier or later.
